// File: rtl/onehot_encoder_pipe_if.sv
// Valid/ready bundle for onehot_encoder_pipe: request lines in, encoded index out.
// The design takes the slave modport and its driver takes the master modport.
interface onehot_encoder_pipe_if #(
   parameter int N = 8
);
   localparam int W = $clog2(N);

   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] out_code;
   logic         out_ok;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_code, out_ok, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_code, out_ok, out_valid
   );
endinterface

// File: rtl/onehot_encoder_pipe.sv
// Registered N-to-log2(N) encoder with valid/ready on both sides; strict one-hot or highest-index-wins.
// Define ONEHOT_ENC_ERRCNT_EN to add the saturating illegal-beat counter (err_clr/err_cnt ports).
module onehot_encoder_pipe #(
   parameter int N        = 8,
   parameter int PRIORITY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   onehot_encoder_pipe_if.slave  bus
`ifdef ONEHOT_ENC_ERRCNT_EN
   ,
   input  logic                  err_clr,
   output logic [7:0]            err_cnt
`endif
);
   localparam int W = $clog2(N);

   logic [W-1:0] enc_code;
   logic         enc_ok;
   logic [W-1:0] code_reg;
   logic         ok_reg;
   logic         valid_reg;
   logic         accept;

   // Bit b of the code is set by every input line whose index has bit b set.
   function automatic logic [N-1:0] bit_mask(input int b);
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) begin
         m[i] = ((i >> b) & 1) != 0;
      end
      return m;
   endfunction

   generate
      if (PRIORITY != 0) begin : g_prio
         always_comb begin
            enc_code = '0;
            for (int i = 0; i < N; i++) begin
               if (bus.in_data[i]) begin
                  enc_code = W'(i);
               end
            end
         end
         assign enc_ok = |bus.in_data;
      end else begin : g_strict
         logic [N-1:0] data;
         logic [W-1:0] or_bits;
         logic         single;

         assign data   = bus.in_data;
         // Nonzero with no second bit set: clearing the lowest set bit leaves zero.
         assign single = (data != '0) && ((data & (data - N'(1))) == '0);

         for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign or_bits[gi] = |(data & bit_mask(gi));
         end

         assign enc_code = single ? or_bits : '0;
         assign enc_ok   = single;
      end
   endgenerate

   assign bus.in_ready = !valid_reg || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= 1'b0;
         code_reg  <= '0;
         ok_reg    <= 1'b0;
      end else if (accept) begin
         valid_reg <= 1'b1;
         code_reg  <= enc_code;
         ok_reg    <= enc_ok;
      end else if (bus.out_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign bus.out_valid = valid_reg;
   assign bus.out_code  = code_reg;
   assign bus.out_ok    = ok_reg;

`ifdef ONEHOT_ENC_ERRCNT_EN
   logic [7:0] err_cnt_reg;

   // Clear wins over a same-cycle illegal beat; the count sticks at 255.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_reg <= 8'd0;
      end else if (err_clr) begin
         err_cnt_reg <= 8'd0;
      end else if (accept && !enc_ok && (err_cnt_reg != 8'hFF)) begin
         err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   assign err_cnt = err_cnt_reg;
`endif
endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Bench for onehot_encoder_pipe: three instances (N=8 strict, N=8 priority, N=5 strict) with scoreboards.
// Counter checks are compiled in when ONEHOT_ENC_ERRCNT_EN is defined.
module tb_onehot_encoder_pipe;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   onehot_encoder_pipe_if #(.N(8)) b0 ();
   onehot_encoder_pipe_if #(.N(8)) b1 ();
   onehot_encoder_pipe_if #(.N(5)) b2 ();

`ifdef ONEHOT_ENC_ERRCNT_EN
   logic       err_clr0 = 1'b0;
   logic       err_clr1 = 1'b0;
   logic       err_clr2 = 1'b0;
   logic [7:0] err_cnt0;
   logic [7:0] err_cnt1;
   logic [7:0] err_cnt2;
`endif

   onehot_encoder_pipe #(.N(8), .PRIORITY(0)) u0 (
      .clk(clk), .rst(rst), .bus(b0)
`ifdef ONEHOT_ENC_ERRCNT_EN
      , .err_clr(err_clr0), .err_cnt(err_cnt0)
`endif
   );
   onehot_encoder_pipe #(.N(8), .PRIORITY(1)) u1 (
      .clk(clk), .rst(rst), .bus(b1)
`ifdef ONEHOT_ENC_ERRCNT_EN
      , .err_clr(err_clr1), .err_cnt(err_cnt1)
`endif
   );
   onehot_encoder_pipe #(.N(5), .PRIORITY(0)) u2 (
      .clk(clk), .rst(rst), .bus(b2)
`ifdef ONEHOT_ENC_ERRCNT_EN
      , .err_clr(err_clr2), .err_cnt(err_cnt2)
`endif
   );

   // Reference encode: returns {ok, code[7:0]}.
   function automatic logic [8:0] ref_enc(input logic [255:0] d, input int n, input int prio);
      int cnt;
      int hi;
      cnt = 0;
      hi  = 0;
      for (int i = 0; i < n; i++) begin
         if (d[i]) begin
            cnt++;
            hi = i;
         end
      end
      if (prio != 0) return (cnt > 0) ? {1'b1, 8'(hi)} : 9'd0;
      return (cnt == 1) ? {1'b1, 8'(hi)} : 9'd0;
   endfunction

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] q2[$];
   logic [8:0] e0, e1, e2;

   always @(negedge clk) begin
      if (!rst) begin
         if (b0.out_valid && b0.out_ready) begin
            checks++;
            if (q0.size() == 0) begin
               failures++;
               $display("FAIL sb0_extra code=%0d ok=%0b required=no_beat", b0.out_code, b0.out_ok);
            end else begin
               e0 = q0.pop_front();
               if (b0.out_code !== e0[2:0] || b0.out_ok !== e0[8]) begin
                  failures++;
                  $display("FAIL sb0 code=%0d ok=%0b required code=%0d ok=%0b", b0.out_code, b0.out_ok, e0[2:0], e0[8]);
               end
            end
         end
         if (b0.in_valid && b0.in_ready) q0.push_back(ref_enc(256'(b0.in_data), 8, 0));
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (b1.out_valid && b1.out_ready) begin
            checks++;
            if (q1.size() == 0) begin
               failures++;
               $display("FAIL sb1_extra code=%0d ok=%0b required=no_beat", b1.out_code, b1.out_ok);
            end else begin
               e1 = q1.pop_front();
               if (b1.out_code !== e1[2:0] || b1.out_ok !== e1[8]) begin
                  failures++;
                  $display("FAIL sb1 code=%0d ok=%0b required code=%0d ok=%0b", b1.out_code, b1.out_ok, e1[2:0], e1[8]);
               end
            end
         end
         if (b1.in_valid && b1.in_ready) q1.push_back(ref_enc(256'(b1.in_data), 8, 1));
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (b2.out_valid && b2.out_ready) begin
            checks++;
            if (q2.size() == 0) begin
               failures++;
               $display("FAIL sb2_extra code=%0d ok=%0b required=no_beat", b2.out_code, b2.out_ok);
            end else begin
               e2 = q2.pop_front();
               if (b2.out_code !== e2[2:0] || b2.out_ok !== e2[8]) begin
                  failures++;
                  $display("FAIL sb2 code=%0d ok=%0b required code=%0d ok=%0b", b2.out_code, b2.out_ok, e2[2:0], e2[8]);
               end
            end
         end
         if (b2.in_valid && b2.in_ready) q2.push_back(ref_enc(256'(b2.in_data), 5, 0));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) step();
      checks++;
      if (b0.out_valid !== 1'b0 || b0.out_code !== 3'd0 || b0.out_ok !== 1'b0 || b0.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_u0 valid=%0b code=%0d ok=%0b ready=%0b required 0/0/0/1", b0.out_valid, b0.out_code, b0.out_ok, b0.in_ready);
      end
      checks++;
      if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1 || b2.out_valid !== 1'b0 || b2.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_u1u2 valid1=%0b ready1=%0b valid2=%0b ready2=%0b required 0/1/0/1", b1.out_valid, b1.in_ready, b2.out_valid, b2.in_ready);
      end
`ifdef ONEHOT_ENC_ERRCNT_EN
      checks++;
      if (err_cnt0 !== 8'd0) begin
         failures++;
         $display("FAIL reset_errcnt got=%0d required=0", err_cnt0);
      end
`endif
      rst = 1'b0;
      $display("reset released at %0t", $time);
   endtask

   task automatic test_stream();
      b0.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b0.in_data  = 8'(1 << i);
         b0.in_valid = 1'b1;
         step();
         $display("stream beat in=%h code=%0d ok=%0b valid=%0b", b0.in_data, b0.out_code, b0.out_ok, b0.out_valid);
         checks++;
         if (b0.out_valid !== 1'b1 || b0.out_code !== 3'(i) || b0.out_ok !== 1'b1) begin
            failures++;
            $display("FAIL stream_%0d valid=%0b code=%0d ok=%0b required 1/%0d/1", i, b0.out_valid, b0.out_code, b0.out_ok, i);
         end
      end
      b0.in_valid = 1'b0;
      step();
      checks++;
      if (b0.out_valid !== 1'b0 || b0.out_code !== 3'd7 || b0.out_ok !== 1'b1) begin
         failures++;
         $display("FAIL stream_hold valid=%0b code=%0d ok=%0b required 0/7/1", b0.out_valid, b0.out_code, b0.out_ok);
      end
      checks++;
      if (q0.size() != 0) begin
         failures++;
         $display("FAIL stream_drain pending=%0d required=0", q0.size());
      end
   endtask

   task automatic test_illegal();
      logic [7:0] vals [2] = '{8'h00, 8'h18};
      b0.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         b0.in_data  = vals[i];
         b0.in_valid = 1'b1;
         step();
         $display("illegal beat in=%h code=%0d ok=%0b", b0.in_data, b0.out_code, b0.out_ok);
         checks++;
         if (b0.out_valid !== 1'b1 || b0.out_code !== 3'd0 || b0.out_ok !== 1'b0) begin
            failures++;
            $display("FAIL illegal_%0d valid=%0b code=%0d ok=%0b required 1/0/0", i, b0.out_valid, b0.out_code, b0.out_ok);
         end
      end
      b0.in_valid = 1'b0;
      step();
`ifdef ONEHOT_ENC_ERRCNT_EN
      checks++;
      if (err_cnt0 !== 8'd2) begin
         failures++;
         $display("FAIL illegal_errcnt got=%0d required=2", err_cnt0);
      end
`endif
   endtask

   task automatic test_priority();
      logic [7:0] vals  [3] = '{8'h18, 8'h01, 8'h00};
      logic [2:0] codes [3] = '{3'd4, 3'd0, 3'd0};
      logic       oks   [3] = '{1'b1, 1'b1, 1'b0};
      b1.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b1.in_data  = vals[i];
         b1.in_valid = 1'b1;
         step();
         $display("priority beat in=%h code=%0d ok=%0b", b1.in_data, b1.out_code, b1.out_ok);
         checks++;
         if (b1.out_valid !== 1'b1 || b1.out_code !== codes[i] || b1.out_ok !== oks[i]) begin
            failures++;
            $display("FAIL priority_%0d valid=%0b code=%0d ok=%0b required 1/%0d/%0b", i, b1.out_valid, b1.out_code, b1.out_ok, codes[i], oks[i]);
         end
      end
      b1.in_valid = 1'b0;
      step();
      checks++;
      if (q1.size() != 0 || b1.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL priority_drain pending=%0d valid=%0b required 0/0", q1.size(), b1.out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] vals [3] = '{8'h01, 8'h02, 8'h81};
      b0.out_ready = 1'b0;
      b0.in_data   = 8'h20;
      b0.in_valid  = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         b0.in_data = vals[k];
         #1;
         $display("hold cycle %0d in=%h ready=%0b code=%0d", k, b0.in_data, b0.in_ready, b0.out_code);
         checks++;
         if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b1 || b0.out_code !== 3'd5 || b0.out_ok !== 1'b1) begin
            failures++;
            $display("FAIL hold_%0d ready=%0b valid=%0b code=%0d ok=%0b required 0/1/5/1", k, b0.in_ready, b0.out_valid, b0.out_code, b0.out_ok);
         end
         step();
      end
      b0.out_ready = 1'b1;
      b0.in_data   = 8'h40;
      #1;
      checks++;
      if (b0.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL release_ready got=%0b required=1", b0.in_ready);
      end
      step();
      checks++;
      if (b0.out_valid !== 1'b1 || b0.out_code !== 3'd6 || b0.out_ok !== 1'b1) begin
         failures++;
         $display("FAIL release_load valid=%0b code=%0d ok=%0b required 1/6/1", b0.out_valid, b0.out_code, b0.out_ok);
      end
      b0.in_valid = 1'b0;
      step();
      checks++;
      if (q0.size() != 0 || b0.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_drain pending=%0d valid=%0b required 0/0", q0.size(), b0.out_valid);
      end
   endtask

   task automatic test_saturation();
      b2.out_ready = 1'b1;
      b2.in_valid  = 1'b1;
      b2.in_data   = 5'h10;
      step();
      checks++;
      if (b2.out_code !== 3'd4 || b2.out_ok !== 1'b1) begin
         failures++;
         $display("FAIL n5_top code=%0d ok=%0b required 4/1", b2.out_code, b2.out_ok);
      end
      b2.in_data = 5'h03;
      repeat (300) step();
      $display("saturation 300 illegal beats sent");
      b2.in_valid = 1'b0;
      step();
`ifdef ONEHOT_ENC_ERRCNT_EN
      checks++;
      if (err_cnt2 !== 8'd255) begin
         failures++;
         $display("FAIL sat_errcnt got=%0d required=255", err_cnt2);
      end
      err_clr2    = 1'b1;
      b2.in_valid = 1'b1;
      step();
      err_clr2    = 1'b0;
      b2.in_valid = 1'b0;
      checks++;
      if (err_cnt2 !== 8'd0) begin
         failures++;
         $display("FAIL clr_errcnt got=%0d required=0", err_cnt2);
      end
      b2.in_valid = 1'b1;
      step();
      b2.in_valid = 1'b0;
      checks++;
      if (err_cnt2 !== 8'd1) begin
         failures++;
         $display("FAIL post_clr_errcnt got=%0d required=1", err_cnt2);
      end
`endif
      step();
      checks++;
      if (q2.size() != 0 || b2.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL sat_drain pending=%0d valid=%0b required 0/0", q2.size(), b2.out_valid);
      end
   endtask

   task automatic test_reset_midtransfer();
      b0.out_ready = 1'b0;
      b0.in_data   = 8'h02;
      b0.in_valid  = 1'b1;
      step();
      b0.in_valid = 1'b0;
      checks++;
      if (b0.out_valid !== 1'b1 || b0.out_code !== 3'd1) begin
         failures++;
         $display("FAIL pre_reset valid=%0b code=%0d required 1/1", b0.out_valid, b0.out_code);
      end
      #2;
      rst = 1'b1;
      #1;
      $display("async reset mid-transfer valid=%0b ready=%0b", b0.out_valid, b0.in_ready);
      checks++;
      if (b0.out_valid !== 1'b0 || b0.out_code !== 3'd0 || b0.out_ok !== 1'b0 || b0.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset valid=%0b code=%0d ok=%0b ready=%0b required 0/0/0/1", b0.out_valid, b0.out_code, b0.out_ok, b0.in_ready);
      end
`ifdef ONEHOT_ENC_ERRCNT_EN
      checks++;
      if (err_cnt0 !== 8'd0) begin
         failures++;
         $display("FAIL async_reset_errcnt got=%0d required=0", err_cnt0);
      end
`endif
      step();
      q0.delete();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      b0.in_data = '0; b0.in_valid = 1'b0; b0.out_ready = 1'b0;
      b1.in_data = '0; b1.in_valid = 1'b0; b1.out_ready = 1'b0;
      b2.in_data = '0; b2.in_valid = 1'b0; b2.out_ready = 1'b0;
      test_reset();
      test_stream();
      test_illegal();
      test_priority();
      test_backpressure();
      test_saturation();
      test_reset_midtransfer();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
